// File: rtl/fp_unit_scheduler_pkg.sv
// Shared definitions for the FP unit scheduler: unit process codes,
// scheduler FSM state encoding and small op-decoding helpers.
package fp_unit_scheduler_pkg;

  // Process select codes understood by the shared FP unit
  localparam logic [1:0] PROCESS_SINGLE_DIVIDER = 2'd0;
  localparam logic [1:0] PROCESS_DOUBLE_DIVIDER = 2'd1;
  localparam logic [1:0] PROCESS_SINGLE_SQRT    = 2'd2;
  localparam logic [1:0] PROCESS_DOUBLE_SQRT    = 2'd3;

  // Width of the optional WAIT_Z watchdog counter
  localparam int FP_SCHED_CNT_W = 16;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    FP_SCHED_IDLE   = 3'd0,
    FP_SCHED_SEND   = 3'd1,
    FP_SCHED_WAIT_Z = 3'd2,
    FP_SCHED_ZACK   = 3'd3,
    FP_SCHED_RESP   = 3'd4
  } fpSchedState_e;

  // Square-root ops take a single operand, so no b transfer is needed
  function automatic logic isSqrt(input logic [1:0] process);
    return (process == PROCESS_SINGLE_SQRT) || (process == PROCESS_DOUBLE_SQRT);
  endfunction

  // Double ops return their result on the 64-bit result bus
  function automatic logic isDouble(input logic [1:0] process);
    return (process == PROCESS_DOUBLE_DIVIDER) || (process == PROCESS_DOUBLE_SQRT);
  endfunction

endpackage

// File: rtl/fp_unit_scheduler_if.sv
// Bus between the scheduler and the shared FP unit: op select, operands,
// operand strobe/ack pairs and the result strobe/ack pair.
// master = scheduler side, slave = FP unit side.
interface fp_unit_scheduler_if;

  logic [1:0]  fpu_process;
  logic [31:0] fpu_as;
  logic [31:0] fpu_bs;
  logic [63:0] fpu_ad;
  logic [63:0] fpu_bd;
  logic        fpu_a_stb;
  logic        fpu_b_stb;
  logic        fpu_a_ack;
  logic        fpu_b_ack;
  logic [31:0] fpu_zs;
  logic [63:0] fpu_zd;
  logic        fpu_z_stb;
  logic        fpu_z_ack;

  modport master (
    output fpu_process, fpu_as, fpu_bs, fpu_ad, fpu_bd,
    output fpu_a_stb, fpu_b_stb, fpu_z_ack,
    input  fpu_a_ack, fpu_b_ack, fpu_zs, fpu_zd, fpu_z_stb
  );

  modport slave (
    input  fpu_process, fpu_as, fpu_bs, fpu_ad, fpu_bd,
    input  fpu_a_stb, fpu_b_stb, fpu_z_ack,
    output fpu_a_ack, fpu_b_ack, fpu_zs, fpu_zd, fpu_z_stb
  );

endinterface

// File: rtl/fp_unit_scheduler_rr_arbiter.sv
// fp_rr_arbiter: combinational rotate-priority pick. Scans the request
// vector starting at ptr_i and wrapping, returning the first set request
// as a one-hot vector and as an index.
module fp_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            valid_o,
  output logic [NREQ-1:0] winner_o,
  output logic [IDXW-1:0] idx_o
);

  logic [IDXW-1:0] cand;

  // Walk the requesters in rotated order and keep the first one found
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx_o    = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((int'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        winner_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/fp_unit_scheduler.sv
// fp_unit_scheduler: shares one FP unit (single/double divide and sqrt)
// between NREQ requesters. Round-robin grant, operand latch, a/b strobe
// handshake to the unit, result capture and z_ack, then a valid/ready
// response back to the winner.
// Optional feature: define FP_SCHED_TIMEOUT_EN to add a WAIT_Z watchdog
// that returns all-ones data with rsp_err after TIMEOUT_CYCLES.
module fp_unit_scheduler
  import fp_unit_scheduler_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  fp_unit_scheduler_if.master  fpu
);

  localparam int IDXW = $clog2(NREQ);

  // Reject configurations the pointer and watchdog widths cannot express
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : gParamCheck
    $error("fp_unit_scheduler: NREQ or TIMEOUT_CYCLES out of range");
  end

  fpSchedState_e   state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      op_q, op_d;
  logic [63:0]     a_q, a_d;
  logic [63:0]     b_q, b_d;
  logic [63:0]     data_q, data_d;
  logic            aStb_q, aStb_d;
  logic            bStb_q, bStb_d;
  logic            aDone_q, aDone_d;
  logic            bDone_q, bDone_d;

`ifdef FP_SCHED_TIMEOUT_EN
  localparam logic [FP_SCHED_CNT_W-1:0] TMO_LAST = FP_SCHED_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [FP_SCHED_CNT_W-1:0] cnt_q, cnt_d;
  logic                      err_q, err_d;
`endif

  logic            arbValid;
  logic [NREQ-1:0] arbWinner;
  logic [IDXW-1:0] arbIdx;
  logic [1:0]      reqOpSel;
  logic            aXfer;
  logic            bXfer;

  fp_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (arbValid),
    .winner_o (arbWinner),
    .idx_o    (arbIdx)
  );

  assign reqOpSel = req_op[int'(arbIdx)*2 +: 2];
  assign aXfer    = aStb_q & fpu.fpu_a_ack;
  assign bXfer    = bStb_q & fpu.fpu_b_ack;

  // Next-state logic: arbitration, operand handshake, result capture, response
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    aStb_d  = aStb_q;
    bStb_d  = bStb_q;
    aDone_d = aDone_q;
    bDone_d = bDone_q;
`ifdef FP_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      FP_SCHED_IDLE: begin
        if (arbValid) begin
          gnt_d   = arbWinner;
          win_d   = arbIdx;
          ptr_d   = (arbIdx == IDXW'(NREQ - 1)) ? '0 : arbIdx + 1'b1;
          op_d    = reqOpSel;
          a_d     = req_a[int'(arbIdx)*64 +: 64];
          b_d     = req_b[int'(arbIdx)*64 +: 64];
          aDone_d = 1'b0;
          bDone_d = isSqrt(reqOpSel);
`ifdef FP_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = FP_SCHED_SEND;
        end
      end
      FP_SCHED_SEND: begin
        if (aXfer) begin
          aStb_d  = 1'b0;
          aDone_d = 1'b1;
        end else if (!aDone_q) begin
          aStb_d  = 1'b1;
        end
        if (bXfer) begin
          bStb_d  = 1'b0;
          bDone_d = 1'b1;
        end else if (!bDone_q) begin
          bStb_d  = 1'b1;
        end
        if ((aDone_q || aXfer) && (bDone_q || bXfer)) begin
          aStb_d  = 1'b0;
          bStb_d  = 1'b0;
`ifdef FP_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = FP_SCHED_WAIT_Z;
        end
      end
      FP_SCHED_WAIT_Z: begin
        if (fpu.fpu_z_stb) begin
          data_d  = isDouble(op_q) ? fpu.fpu_zd : {32'h0, fpu.fpu_zs};
          state_d = FP_SCHED_ZACK;
        end
`ifdef FP_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          data_d  = '1;
          err_d   = 1'b1;
          state_d = FP_SCHED_RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      FP_SCHED_ZACK: begin
        if (!fpu.fpu_z_stb) begin
          state_d = FP_SCHED_RESP;
        end
      end
      FP_SCHED_RESP: begin
        if (rsp_ready[win_q]) begin
          state_d = FP_SCHED_IDLE;
        end
      end
      default: begin
        state_d = FP_SCHED_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset returns everything to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FP_SCHED_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      aStb_q  <= 1'b0;
      bStb_q  <= 1'b0;
      aDone_q <= 1'b0;
      bDone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      aStb_q  <= aStb_d;
      bStb_q  <= bStb_d;
      aDone_q <= aDone_d;
      bDone_q <= bDone_d;
    end
  end

`ifdef FP_SCHED_TIMEOUT_EN
  // Watchdog counter and timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign rsp_valid = (state_q == FP_SCHED_RESP) ? (NREQ'(1) << win_q) : '0;
  assign rsp_data  = data_q;

  assign fpu.fpu_process = op_q;
  assign fpu.fpu_as      = a_q[31:0];
  assign fpu.fpu_bs      = b_q[31:0];
  assign fpu.fpu_ad      = a_q;
  assign fpu.fpu_bd      = b_q;
  assign fpu.fpu_a_stb   = aStb_q;
  assign fpu.fpu_b_stb   = bStb_q;
  assign fpu.fpu_z_ack   = (state_q == FP_SCHED_ZACK);

endmodule

// File: tb/tb_fp_unit_scheduler.sv
// Directed testbench for fp_unit_scheduler with a small behavioural FP unit
// responder. The timeout scenario runs only when FP_SCHED_TIMEOUT_EN is set.
module tb_fp_unit_scheduler;
  import fp_unit_scheduler_pkg::*;

  localparam int NREQ = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [7:0]    req_op;
  logic [255:0]  req_a;
  logic [255:0]  req_b;
  logic [3:0]    gnt;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [63:0]   rsp_data;
  logic          rsp_err;

  int compared   = 0;
  int mismatched = 0;

  // Unit model controls and observations
  logic [31:0] modelZs;
  logic [63:0] modelZd;
  bit          zStuck;
  bit          gotA, gotB, bWait, bStbEver, zAckSeen;
  int          zPhase, zCount;
  logic [31:0] seenAs, seenBs;
  logic [63:0] seenAd;
  logic [1:0]  seenProc;

  fp_unit_scheduler_if fpuIf ();

  fp_unit_scheduler #(
    .NREQ           (NREQ),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .fpu       (fpuIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FP unit: acks a at once, b one cycle later, raises z_stb
  // three cycles after the operands are in, drops it once z_ack is seen
  always @(negedge clk) begin
    if (!rst) begin
      fpuIf.fpu_a_ack = 1'b0;
      fpuIf.fpu_b_ack = 1'b0;
      fpuIf.fpu_z_stb = 1'b0;
      fpuIf.fpu_zs    = '0;
      fpuIf.fpu_zd    = '0;
      gotA = 0; gotB = 0; bWait = 0; bStbEver = 0; zAckSeen = 0;
      zPhase = 0; zCount = 0;
      seenAs = '0; seenBs = '0; seenAd = '0; seenProc = '0;
    end else begin
      if (gnt != '0) begin
        gotA = 0; gotB = 0; bWait = 0; bStbEver = 0; zAckSeen = 0; zPhase = 0;
      end
      if (fpuIf.fpu_b_stb) bStbEver = 1;
      if (fpuIf.fpu_z_ack) zAckSeen = 1;
      if (fpuIf.fpu_a_stb && !fpuIf.fpu_a_ack) begin
        fpuIf.fpu_a_ack = 1'b1;
        gotA     = 1;
        seenAs   = fpuIf.fpu_as;
        seenAd   = fpuIf.fpu_ad;
        seenProc = fpuIf.fpu_process;
      end else begin
        fpuIf.fpu_a_ack = 1'b0;
      end
      if (fpuIf.fpu_b_stb && !fpuIf.fpu_b_ack) begin
        if (bWait) begin
          fpuIf.fpu_b_ack = 1'b1;
          gotB   = 1;
          bWait  = 0;
          seenBs = fpuIf.fpu_bs;
        end else begin
          bWait = 1;
        end
      end else begin
        fpuIf.fpu_b_ack = 1'b0;
      end
      if (zPhase == 0 && gotA && (gotB || seenProc[1]) && !fpuIf.fpu_a_stb &&
          !fpuIf.fpu_b_stb && !zStuck) begin
        zPhase = 1;
        zCount = 0;
      end else if (zPhase == 1) begin
        zCount++;
        if (zCount == 3) begin
          fpuIf.fpu_z_stb = 1'b1;
          fpuIf.fpu_zs    = modelZs;
          fpuIf.fpu_zd    = modelZd;
          zPhase = 2;
        end
      end else if (zPhase == 2 && fpuIf.fpu_z_ack) begin
        fpuIf.fpu_z_stb = 1'b0;
        zPhase = 0;
        gotA = 0;
        gotB = 0;
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    req_op[idx*2 +: 2]  = op;
    req_a[idx*64 +: 64] = a;
    req_b[idx*64 +: 64] = b;
    req[idx]            = 1'b1;
  endtask

  task automatic waitForGnt(input int budget, output logic [3:0] seen);
    seen = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        seen = gnt;
        break;
      end
    end
    if (seen == '0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL gnt_timeout observed=none expected=grant");
    end
  endtask

  task automatic waitForRsp(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL rsp_timeout observed=none expected=rsp_valid");
    end
  endtask

  task automatic takeResponse(input string tag, input int idx);
    logic [3:0] oneHot;
    oneHot    = 4'b0001 << idx;
    rsp_ready = oneHot;
    @(negedge clk);
    rsp_ready = '0;
    checkOutput({tag, "_release"}, 64'(rsp_valid), 64'h0);
  endtask

  task automatic serveOne(input string tag, input int expIdx, input logic [31:0] zsVal,
                          input logic [63:0] zdVal, input logic [63:0] expData, input logic [3:0] clearMask);
    logic [3:0] seen;
    logic [3:0] oneHot;
    oneHot  = 4'b0001 << expIdx;
    modelZs = zsVal;
    modelZd = zdVal;
    waitForGnt(40, seen);
    checkOutput({tag, "_gnt"}, 64'(seen), 64'(oneHot));
    req = req & ~clearMask;
    waitForRsp(80);
    checkOutput({tag, "_valid"}, 64'(rsp_valid), 64'(oneHot));
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkOutput({tag, "_err"}, 64'(rsp_err), 64'h0);
    takeResponse(tag, expIdx);
  endtask

  initial begin
    logic [3:0] seen;
    rst       = 1'b0;
    req       = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    zStuck    = 0;
    modelZs   = '0;
    modelZd   = '0;

    // Reset state
    #1;
    checkOutput("reset_gnt", 64'(gnt), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_a_stb", 64'(fpuIf.fpu_a_stb), 64'h0);
    checkOutput("reset_b_stb", 64'(fpuIf.fpu_b_stb), 64'h0);
    checkOutput("reset_z_ack", 64'(fpuIf.fpu_z_ack), 64'h0);
    checkOutput("reset_rsp_data", rsp_data, 64'h0);
    #21 rst = 1'b1;
    @(negedge clk);

    // Test 1: single divide 1.0/2.0 from requester 0, with latency checks
    $display("[TB] test 1: single divide on requester 0");
    modelZs = 32'h3F00_0000;
    modelZd = 64'hDEAD_BEEF_CAFE_F00D;
    applyStimulus(0, PROCESS_SINGLE_DIVIDER, 64'h3F80_0000, 64'h4000_0000);
    @(negedge clk);
    checkOutput("t1_gnt_latency", 64'(gnt), 64'h1);
    checkOutput("t1_a_stb_with_gnt", 64'(fpuIf.fpu_a_stb), 64'h0);
    req[0] = 1'b0;
    @(negedge clk);
    checkOutput("t1_gnt_pulse", 64'(gnt), 64'h0);
    checkOutput("t1_a_stb_after_gnt", 64'(fpuIf.fpu_a_stb), 64'h1);
    checkOutput("t1_b_stb_after_gnt", 64'(fpuIf.fpu_b_stb), 64'h1);
    waitForRsp(60);
    checkOutput("t1_valid", 64'(rsp_valid), 64'h1);
    checkOutput("t1_data", rsp_data, 64'h0000_0000_3F00_0000);
    checkOutput("t1_err", 64'(rsp_err), 64'h0);
    checkOutput("t1_unit_as", 64'(seenAs), 64'h3F80_0000);
    checkOutput("t1_unit_bs", 64'(seenBs), 64'h4000_0000);
    checkOutput("t1_unit_process", 64'(seenProc), 64'(PROCESS_SINGLE_DIVIDER));
    checkOutput("t1_z_ack_seen", 64'(zAckSeen), 64'h1);
    takeResponse("t1", 0);

    // Test 2: double sqrt of 4.0 from requester 2, b strobe must stay low
    $display("[TB] test 2: double sqrt on requester 2");
    applyStimulus(2, PROCESS_DOUBLE_SQRT, 64'h4010_0000_0000_0000, 64'h0123_4567_89AB_CDEF);
    serveOne("t2", 2, 32'h0BAD_F00D, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'b0100);
    checkOutput("t2_b_stb_never", 64'(bStbEver), 64'h0);
    checkOutput("t2_unit_ad", seenAd, 64'h4010_0000_0000_0000);
    checkOutput("t2_unit_process", 64'(seenProc), 64'(PROCESS_DOUBLE_SQRT));

    // Test 3: requesters 0 and 1 held through three ops, pointer wraps 3 -> 0
    $display("[TB] test 3: round-robin order with held requests");
    applyStimulus(0, PROCESS_SINGLE_DIVIDER, 64'h4040_0000, 64'h4000_0000);
    applyStimulus(1, PROCESS_SINGLE_DIVIDER, 64'h4120_0000, 64'h40A0_0000);
    serveOne("t3_op1", 0, 32'h3FC0_0000, 64'h5555_5555_5555_5555, 64'h0000_0000_3FC0_0000, 4'b0000);
    serveOne("t3_op2", 1, 32'h4000_0000, 64'h5555_5555_5555_5555, 64'h0000_0000_4000_0000, 4'b0000);
    serveOne("t3_op3", 0, 32'h3FC0_0000, 64'h5555_5555_5555_5555, 64'h0000_0000_3FC0_0000, 4'b0011);

    // Test 4: response stalled for 20 cycles, other ready bits ignored
    $display("[TB] test 4: stalled response on requester 1");
    modelZs = 32'h1111_1111;
    modelZd = 64'h4000_0000_0000_0000;
    applyStimulus(1, PROCESS_DOUBLE_DIVIDER, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    waitForGnt(40, seen);
    checkOutput("t4_gnt", 64'(seen), 64'h2);
    req[1] = 1'b0;
    waitForRsp(80);
    applyStimulus(3, PROCESS_SINGLE_SQRT, 64'h4180_0000, 64'h0);
    rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", 64'(rsp_valid), 64'h2);
      checkOutput("t4_hold_data", rsp_data, 64'h4000_0000_0000_0000);
      checkOutput("t4_hold_no_gnt", 64'(gnt), 64'h0);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    checkOutput("t4_release_valid", 64'(rsp_valid), 64'h0);
    checkOutput("t4_no_gnt_at_handoff", 64'(gnt), 64'h0);
    serveOne("t4_req3", 3, 32'h4080_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_4080_0000, 4'b1000);

    // Test 5: async reset while waiting for the result
    $display("[TB] test 5: reset during WAIT_Z");
    zStuck = 1;
    applyStimulus(0, PROCESS_SINGLE_SQRT, 64'h4080_0000, 64'h0);
    waitForGnt(40, seen);
    checkOutput("t5_gnt", 64'(seen), 64'h1);
    req[0] = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_waitz_a_stb", 64'(fpuIf.fpu_a_stb), 64'h0);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_rst_gnt", 64'(gnt), 64'h0);
    checkOutput("t5_rst_valid", 64'(rsp_valid), 64'h0);
    checkOutput("t5_rst_a_stb", 64'(fpuIf.fpu_a_stb), 64'h0);
    checkOutput("t5_rst_b_stb", 64'(fpuIf.fpu_b_stb), 64'h0);
    checkOutput("t5_rst_z_ack", 64'(fpuIf.fpu_z_ack), 64'h0);
    checkOutput("t5_rst_data", rsp_data, 64'h0);
    checkOutput("t5_rst_process", 64'(fpuIf.fpu_process), 64'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    zStuck = 0;
    @(negedge clk);
    applyStimulus(0, PROCESS_SINGLE_DIVIDER, 64'h40C0_0000, 64'h4040_0000);
    applyStimulus(2, PROCESS_DOUBLE_SQRT, 64'h4022_0000_0000_0000, 64'h0);
    serveOne("t5_after_a", 0, 32'h4000_0000, 64'h7777_7777_7777_7777, 64'h0000_0000_4000_0000, 4'b0001);
    serveOne("t5_after_b", 2, 32'h7777_7777, 64'h4008_0000_0000_0000, 64'h4008_0000_0000_0000, 4'b0100);

`ifdef FP_SCHED_TIMEOUT_EN
    // Test 6: unit never answers, watchdog fires 16 cycles after WAIT_Z entry
    begin
      bit earlyValid;
      $display("[TB] test 6: WAIT_Z timeout");
      zStuck     = 1;
      earlyValid = 0;
      applyStimulus(1, PROCESS_SINGLE_DIVIDER, 64'h3F80_0000, 64'h4000_0000);
      waitForGnt(40, seen);
      checkOutput("t6_gnt", 64'(seen), 64'h2);
      req[1] = 1'b0;
      for (int c = 0; c < 18; c++) begin
        @(negedge clk);
        if (rsp_valid != '0) earlyValid = 1;
      end
      checkOutput("t6_no_early_valid", 64'(earlyValid), 64'h0);
      @(negedge clk);
      checkOutput("t6_valid", 64'(rsp_valid), 64'h2);
      checkOutput("t6_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("t6_err", 64'(rsp_err), 64'h1);
      checkOutput("t6_no_z_ack", 64'(zAckSeen), 64'h0);
      zStuck = 0;
      takeResponse("t6", 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
